// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side consumer of a 16-deep FIFO status block.
// Watches fifo_empty/fifo_threshold and issues single-word rd strobes in bursts.
// Each word returned one cycle after its rd is captured into a 2-entry buffer.
// The buffer drains onto a valid/ready stream, and the last word of each burst
// carries m_last.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                permit new bursts (a running burst always completes)
//   fifo_empty        FIFO empty status
//   fifo_threshold    FIFO occupancy >= 8
//   fifo_underflow    FIFO underflow flag
//   fifo_rd_data      FIFO read data, valid the cycle after rd
//   rd                FIFO read strobe (combinational)
//   m_data, m_valid,
//   m_last, m_ready   output stream; a transfer is m_valid & m_ready
//   busy              burst active, buffer non-empty or read in flight
//   burst_done        one-cycle pulse after a burst ends
//   err_underflow     sticky underflow error flag
//   err_clr           clears err_underflow (a new underflow takes priority)
module fifo_drain_ctrl #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MAX_BURST     = 8,
  parameter int unsigned FLUSH_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              fifo_threshold,
  input  logic              fifo_underflow,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              rd,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              burst_done,
  output logic              err_underflow,
  input  logic              err_clr
);

  localparam int unsigned BEAT_W  = 8;
  localparam int unsigned IDLE_W  = 16;
  localparam int unsigned ENTRY_W = DATA_W + 1;

  localparam logic [BEAT_W-1:0] BEAT_MAX   = BEAT_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                rd_q;
  logic                tag_q, tag_d;
  logic [1:0]          occ_q, occ_d;
  // Buffer entries are {last, data}; entry 0 is the head. Slots at or beyond
  // occ_q are kept at zero so an empty buffer presents m_data=0, m_last=0.
  logic [ENTRY_W-1:0]  buf0_q, buf0_d;
  logic [ENTRY_W-1:0]  buf1_q, buf1_d;
  logic                busy_q, busy_d;
  logic                burst_done_q, burst_done_d;
  logic                err_q, err_d;

  logic                pop;
  logic                push;
  logic                push_last;
  logic [ENTRY_W-1:0]  push_entry;
  logic [2:0]          occ_proj;
  logic                last_beat;
  logic                empty_exit;
  logic                drain_exit;
  logic                start_burst;

  // Read strobe and burst control decode.
  always_comb begin
    pop  = (occ_q != 2'd0) & m_ready;
    push = rd_q;
    // Projected occupancy once the in-flight word lands and any pop retires.
    occ_proj = 3'(occ_q) + 3'(rd_q) - 3'(pop);
    rd = (state_q == S_DRAIN) & ~fifo_empty & (occ_proj < 3'd2) &
         (beat_cnt_q < BEAT_MAX);
    last_beat  = rd & (beat_cnt_q == BEAT_LAST);
    // FIFO ran dry mid-burst: the word still in flight closes the burst.
    empty_exit = (state_q == S_DRAIN) & fifo_empty;
    drain_exit = last_beat | empty_exit;
    start_burst = (state_q == S_IDLE) & en & ~fifo_empty &
                  (fifo_threshold | (idle_cnt_q == IDLE_LIMIT));
    push_last  = tag_q | empty_exit;
    push_entry = {push_last, fifo_rd_data};
  end

  // Next-state logic for FSM, counters, buffer and status flags.
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    occ_d        = occ_q;
    tag_d        = last_beat;
    burst_done_d = drain_exit;
    err_d        = err_q;
    busy_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_burst) begin
          state_d    = S_DRAIN;
          idle_cnt_d = '0;
          beat_cnt_d = '0;
        end else if (fifo_empty) begin
          idle_cnt_d = '0;
        end else if (en && (idle_cnt_q < IDLE_LIMIT)) begin
          // With en low the flush timer is frozen.
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (rd) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (drain_exit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Two-entry shift buffer: pop moves entry 1 to the head.
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = push_entry;
        end else begin
          buf1_d = push_entry;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = '0;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = push_entry;
        end else begin
          buf0_d = buf1_q;
          buf1_d = push_entry;
        end
      end
      default: ;
    endcase

    // Sticky error: a new underflow wins over a simultaneous clear.
    if (fifo_underflow) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE) | (occ_d != 2'd0) | rd;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idle_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      rd_q         <= 1'b0;
      tag_q        <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_q         <= rd;
      tag_q        <= tag_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
      err_q        <= err_d;
    end
  end

  assign m_data        = buf0_q[DATA_W-1:0];
  assign m_last        = buf0_q[DATA_W];
  assign m_valid       = (occ_q != 2'd0);
  assign busy          = busy_q;
  assign burst_done    = burst_done_q;
  assign err_underflow = err_q;

`ifndef SYNTHESIS
  // The rd gating guarantees a free slot for every captured word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ_q == 2'd2) && !pop));
  a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd && fifo_empty));
`endif

endmodule
